alu_mp_seq: RTL and testbench

- Multi-precision operation sequencer in front of the combinational ALU.
- Accepts one wide request (NUM_WORDS × REG_WIDTH operands plus a 4-bit opcode) over a valid/ready handshake.
- Issues the operation to the ALU one word per cycle, least-significant word first, chaining carry between words.
- Returns the assembled wide result on a valid/ready response channel.

---
 rtl/alu_mp_seq.sv | 151 +++++++++++++++
 tb/tb_alu_mp_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mp_seq.sv
// Multi-precision operation sequencer in front of a combinational word ALU.
// A wide request is accepted on req_*, sent to the ALU one word per cycle
// (least-significant word first, carry chained between words), and the
// assembled result is returned on resp_*.
//
// Handshake semantics (both channels): a transfer happens at a rising clk
// edge where valid and ready are both high. The producer holds valid and its
// payload stable until that transfer. The consumer may raise or lower ready
// at any time. req_ready_o and resp_valid_o are derived from registered
// state only, so there is no combinational path from req_valid_i or
// resp_ready_i to any output.
module alu_mp_seq #(
  parameter int REG_WIDTH = 8,
  parameter int NUM_WORDS = 4,
  parameter int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [3:0]                     req_instr_i,
  input  logic [NUM_WORDS*REG_WIDTH-1:0] req_a_i,
  input  logic [NUM_WORDS*REG_WIDTH-1:0] req_b_i,
  output logic                           resp_valid_o,
  input  logic                           resp_ready_i,
  output logic [NUM_WORDS*REG_WIDTH-1:0] resp_result_o,
  output logic                           resp_cout_o,
  output logic                           resp_err_o,
  output logic                           busy_o,
  output logic [3:0]                     alu_instr_o,
  output logic [REG_WIDTH-1:0]           alu_a_o,
  output logic [REG_WIDTH-1:0]           alu_b_o,
  output logic                           alu_cin_o,
  input  logic [REG_WIDTH-1:0]           alu_acc_i,
  input  logic                           alu_cout_i,
  output logic [1:0]                     dbg_state_o
);

  localparam int DW = NUM_WORDS * REG_WIDTH;

  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_MAX = 4'd8;   // highest supported opcode
  localparam logic [3:0] OP_NOP = 4'hF;   // ALU decodes this as no-op

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [DW-1:0]    a_q;
  logic [DW-1:0]    b_q;
  logic [3:0]       op_q;
  logic [DW-1:0]    result_q;
  logic             carry_q;
  logic             resp_cout_q;
  logic             resp_err_q;
  logic             req_ready_q;
  logic             is_arith;

  assign is_arith      = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = (state_q == ST_RESP);
  assign resp_result_o = result_q;
  assign resp_cout_o   = resp_cout_q;
  assign resp_err_o    = resp_err_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign dbg_state_o   = state_q;

  // Drive the ALU with the current word during EXEC; park it on a no-op otherwise.
  always_comb begin
    alu_instr_o = OP_NOP;
    alu_a_o     = '0;
    alu_b_o     = '0;
    alu_cin_o   = 1'b0;
    if (state_q == ST_EXEC) begin
      alu_instr_o = op_q;
      alu_a_o     = a_q[REG_WIDTH*int'(idx_q) +: REG_WIDTH];
      alu_b_o     = b_q[REG_WIDTH*int'(idx_q) +: REG_WIDTH];
      // Word 0 seeds SUB's +1 of two's complement; higher words chain the carry.
      if (idx_q == '0) alu_cin_o = (op_q == OP_SUB);
      else             alu_cin_o = is_arith & carry_q;
    end
  end

  // Sequencer FSM: accept, walk the words through the ALU, hold the response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      resp_cout_q <= 1'b0;
      resp_err_q  <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            a_q         <= req_a_i;
            b_q         <= req_b_i;
            op_q        <= req_instr_i;
            result_q    <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            resp_cout_q <= 1'b0;
            req_ready_q <= 1'b0;
            if (req_instr_i <= OP_MAX) begin
              resp_err_q <= 1'b0;
              state_q    <= ST_EXEC;
            end else begin
              // Unsupported opcode: report immediately without touching the ALU.
              resp_err_q <= 1'b1;
              state_q    <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          result_q[REG_WIDTH*int'(idx_q) +: REG_WIDTH] <= alu_acc_i;
          carry_q <= alu_cout_i;
          if (idx_q == LAST_IDX) begin
            resp_cout_q <= is_arith & alu_cout_i;
            state_q     <= ST_RESP;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mp_seq.sv
// Bench for alu_mp_seq: a word ALU model sits on the alu_* ports, directed
// table vectors and hand-written corner sequences run first, then random
// requests are checked against a whole-operand arithmetic model.
module tb_alu_mp_seq;

  localparam int RW = 8;
  localparam int NW = 4;
  localparam int DW = RW * NW;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_instr = '0;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_result;
  logic          resp_cout;
  logic          resp_err;
  logic          busy;
  logic [3:0]    alu_instr;
  logic [RW-1:0] alu_a;
  logic [RW-1:0] alu_b;
  logic          alu_cin;
  logic [RW-1:0] alu_acc;
  logic          alu_cout;
  logic [1:0]    dbg_state;
  logic [RW:0]   alu_sum;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW+1:0] exp_q[$];   // {err, cout, result}

  always #5 clk = ~clk;

  alu_mp_seq #(.REG_WIDTH(RW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_instr_i(req_instr),
    .req_a_i(req_a), .req_b_i(req_b),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_result_o(resp_result), .resp_cout_o(resp_cout), .resp_err_o(resp_err),
    .busy_o(busy),
    .alu_instr_o(alu_instr), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin),
    .alu_acc_i(alu_acc), .alu_cout_i(alu_cout),
    .dbg_state_o(dbg_state)
  );

  // Combinational word ALU seen by the sequencer.
  always_comb begin
    alu_sum  = '0;
    alu_acc  = '0;
    alu_cout = 1'b0;
    case (alu_instr)
      4'd0: alu_acc = ~alu_a;
      4'd1: alu_acc = alu_a & alu_b;
      4'd2: alu_acc = alu_a | alu_b;
      4'd3: alu_acc = alu_a ^ alu_b;
      4'd4: begin
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {{RW{1'b0}}, alu_cin};
        alu_acc  = alu_sum[RW-1:0];
        alu_cout = alu_sum[RW];
      end
      4'd5: begin
        alu_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + {{RW{1'b0}}, alu_cin};
        alu_acc  = alu_sum[RW-1:0];
        alu_cout = alu_sum[RW];
      end
      4'd6: alu_acc = ~(alu_a & alu_b);
      4'd7: alu_acc = ~(alu_a | alu_b);
      4'd8: alu_acc = ~(alu_a ^ alu_b);
      default: alu_acc = '0;
    endcase
  end

  // ---------------- reference model ----------------
  // Whole-operand result: {err, cout, result}.
  function automatic logic [DW+1:0] model(input logic [3:0] op, input logic [DW-1:0] a, b);
    logic [DW:0] s;
    case (op)
      4'd0: return {2'b00, ~a};
      4'd1: return {2'b00, a & b};
      4'd2: return {2'b00, a | b};
      4'd3: return {2'b00, a ^ b};
      4'd4: begin s = {1'b0, a} + {1'b0, b};               return {1'b0, s}; end
      4'd5: begin s = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1); return {1'b0, s}; end
      4'd6: return {2'b00, ~(a & b)};
      4'd7: return {2'b00, ~(a | b)};
      4'd8: return {2'b00, ~(a ^ b)};
      default: return {2'b10, {DW{1'b0}}};
    endcase
  endfunction

  // Carry into word k: the carry out of the low k words computed as one sum.
  function automatic logic cin_model(input logic [3:0] op, input logic [DW-1:0] a, b, input int k);
    longint unsigned m, s;
    if (k == 0) return (op == 4'd5);
    if (op != 4'd4 && op != 4'd5) return 1'b0;
    m = (64'd1 << (RW * k)) - 64'd1;
    if (op == 4'd4) s = (64'(a) & m) + (64'(b) & m);
    else            s = (64'(a) & m) + (64'(~b) & m) + 64'd1;
    return s[RW*k];
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " req_ready wait"}, 64'(req_ready), 64'd1);
  endtask

  // ---------------- driver: one full transaction ----------------
  task automatic run_txn(input string tag, input logic [3:0] op,
                         input logic [DW-1:0] a, b, input logic [DW+1:0] exp);
    int lat;
    logic cin_seen[$];
    logic [3:0] instr_seen[$];
    logic [DW+1:0] want;
    exp_q.push_back(exp);
    wait_ready(tag);
    req_valid = 1'b1; req_instr = op; req_a = a; req_b = b;
    @(posedge clk); #1;   // accepting edge
    // Scramble the request bus: it must not influence the running operation.
    req_valid = 1'b0; req_instr = 4'($urandom); req_a = $urandom; req_b = $urandom;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      cin_seen.push_back(alu_cin);
      instr_seen.push_back(alu_instr);
      @(posedge clk); #1;
      lat++;
    end
    if (exp[DW+1]) begin
      // Error responses appear at the accepting edge itself.
      check({tag, " err latency"}, 64'(lat), 64'd0);
      check({tag, " err alu_instr parked"}, 64'(alu_instr), 64'hF);
    end else begin
      check({tag, " latency"}, 64'(lat), 64'(NW));
      for (int w = 0; w < cin_seen.size() && w < NW; w++) begin
        check($sformatf("%s cin[%0d]", tag, w), 64'(cin_seen[w]), 64'(cin_model(op, a, b, w)));
        check($sformatf("%s instr[%0d]", tag, w), 64'(instr_seen[w]), 64'(op));
      end
    end
    want = exp_q.pop_front();
    check({tag, " result"}, 64'(resp_result), 64'(want[DW-1:0]));
    check({tag, " cout"}, 64'(resp_cout), 64'(want[DW]));
    check({tag, " err"}, 64'(resp_err), 64'(want[DW+1]));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, " valid drop"}, 64'(resp_valid), 64'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          cout;
    logic          err;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rop;
    logic [DW-1:0] ra, rb;
    int bad;

    tbl[0]  = '{4'h4, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0};
    tbl[1]  = '{4'h5, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1'b0};
    tbl[2]  = '{4'h5, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[3]  = '{4'h4, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    tbl[4]  = '{4'h3, 32'hF0F0AA55, 32'hFFFF0000, 32'h0F0FAA55, 1'b0, 1'b0};
    tbl[5]  = '{4'hA, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1};
    tbl[6]  = '{4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1};
    tbl[7]  = '{4'h0, 32'h12345678, 32'h00000000, 32'hEDCBA987, 1'b0, 1'b0};
    tbl[8]  = '{4'h1, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0};
    tbl[9]  = '{4'h2, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0};
    tbl[10] = '{4'h6, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0};
    tbl[11] = '{4'h7, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[12] = '{4'h5, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b1, 1'b0};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_err", 64'(resp_err), 64'd0);
    check("rst resp_cout", 64'(resp_cout), 64'd0);
    check("rst resp_result", 64'(resp_result), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst alu_instr", 64'(alu_instr), 64'hF);
    reset_n = 1'b1;
    check("rst req_ready before edge", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("rst req_ready after edge", 64'(req_ready), 64'd1);

    // ---- table vectors ----
    for (int i = 0; i < 13; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
              {tbl[i].err, tbl[i].cout, tbl[i].res});

    // ---- backpressure ----
    wait_ready("bp");
    req_valid = 1'b1; req_instr = 4'h4; req_a = 32'h10; req_b = 32'h20;
    @(posedge clk); #1;
    req_a = 32'h1; req_b = 32'h2;   // second request stays presented
    for (int n = 0; n < 20 && !resp_valid; n++) begin
      @(posedge clk); #1;
    end
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (resp_valid !== 1'b1 || resp_result !== 32'h30 || req_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("bp held cycles bad", 64'(bad), 64'd0);
    check("bp result", 64'(resp_result), 64'h30);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp valid after hs", 64'(resp_valid), 64'd0);
    check("bp ready after hs", 64'(req_ready), 64'd1);
    check("bp busy after hs", 64'(busy), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp second accepted", 64'(busy), 64'd1);
    for (int n = 0; n < 20 && !resp_valid; n++) begin
      @(posedge clk); #1;
    end
    check("bp second result", 64'(resp_result), 64'h3);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // ---- reset during EXEC word 2 ----
    wait_ready("rstx");
    req_valid = 1'b1; req_instr = 4'h4; req_a = 32'h44332211; req_b = 32'h01010101;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstx on word2", 64'(alu_a), 64'h33);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rstx busy", 64'(busy), 64'd0);
    check("rstx resp_valid", 64'(resp_valid), 64'd0);
    check("rstx req_ready", 64'(req_ready), 64'd0);
    check("rstx result", 64'(resp_result), 64'd0);
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) bad++;
    end
    check("rstx no response", 64'(bad), 64'd0);
    run_txn("post_rst", 4'h4, 32'h1, 32'h1, {2'b00, 32'h00000002});

    // ---- random against model ----
    for (int i = 0; i < 40; i++) begin
      rop = (($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ~ra + DW'(1);
      run_txn($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
